sync_debounce: RTL
==================

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter DATA_WIDTH, default 4: number of independent single-bit lanes.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive differing samples required to commit a level change; legal range 1..65535, elaboration error otherwise.
REQ-003 Parameter CNT_WIDTH, default 8: width of each per-lane event counter; minimum 1.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in  input  DATA_WIDTH: lanes already synchronized into the clk domain by an upstream two-flop synchronizer; no further synchronization is performed here.
REQ-007 clr_cnt  input  1: synchronous clear of all event counters.
REQ-008 level  output  DATA_WIDTH: debounced, registered level per lane.
REQ-009 rise  output  DATA_WIDTH: one-cycle pulse per lane on a committed 0->1 transition.
REQ-010 fall  output  DATA_WIDTH: one-cycle pulse per lane on a committed 1->0 transition.
REQ-011 event_cnt  output  DATA_WIDTH*CNT_WIDTH: per-lane counter of committed transitions; lane i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-012 Each lane SHALL operate independently with an identical 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-013 STABLE_LO: in=0 -> stay, stability counter 0; in=1 -> PEND_HI, counter 1 (or commit immediately when DEBOUNCE_CYCLES=1).
REQ-014 PEND_HI: in=1 -> counter+1; on the edge where the counter reaches DEBOUNCE_CYCLES -> STABLE_HI; in=0 -> STABLE_LO, counter 0, no pulse.
REQ-015 STABLE_HI and PEND_LO SHALL mirror REQ-013/REQ-014 with polarities swapped.
REQ-016 level SHALL update on the same edge that enters STABLE_HI/STABLE_LO from a PEND state, i.e. DEBOUNCE_CYCLES edges after the first differing sample is captured.
REQ-017 rise/fall SHALL be registered and high for exactly the one cycle in which level has just changed; never both high on one lane.
REQ-018 With DEBOUNCE_CYCLES=1, level SHALL equal in delayed by one cycle, with a rise/fall pulse on every change.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change, no pulse, no count.
REQ-020 Stability counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; it never exceeds DEBOUNCE_CYCLES.
REQ-021 event_cnt SHALL increment by 1 on each committed rise or fall and saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-022 clr_cnt and a commit on the same edge SHALL leave that lane's counter at 1; clr_cnt alone leaves 0.
REQ-023 All outputs SHALL be driven directly from flops; no combinational path from in to any output.

Reset
REQ-024 On rst at a clock edge: all FSMs STABLE_LO, stability counters 0, level 0, rise 0, fall 0, event_cnt 0.
REQ-025 rst SHALL take priority over clr_cnt and over any pending commit; a transition in PEND state when rst asserts is discarded.
REQ-026 After rst deasserts, a lane held at in=1 SHALL commit rise after DEBOUNCE_CYCLES edges as per REQ-014.

Structure
REQ-027 Shared package sync_pkg SHALL hold the lane state enum typedef (debounce_state_e) and its encoding.
REQ-028 Per-lane logic SHALL be a sub-module sync_debounce_lane (FSM, stability counter, level, pulse, event counter), instantiated DATA_WIDTH times via generate.
REQ-029 The top level SHALL contain only parameter checks, generate loop and event_cnt packing.

Verification (DATA_WIDTH=4, DEBOUNCE_CYCLES=4, CNT_WIDTH=8)
REQ-030 Hold in[0]=1 from cycle 10 -> level[0]=1 and rise[0]=1 for one cycle at cycle 14; event_cnt lane0=1; other lanes unchanged.
REQ-031 in[1]=1 for 3 cycles then 0 -> level[1] stays 0, no rise/fall, event_cnt lane1=0.
REQ-032 Toggle in[2] with stable periods of 6 cycles, 300 transitions -> event_cnt lane2 saturates at 255 and holds.
REQ-033 Commit on lane3 in the same cycle as clr_cnt=1 -> event_cnt lane3=1; other lanes 0.
REQ-034 rst asserted in the 2nd cycle of PEND_HI on lane0 -> after reset level[0]=0, no pulse; in held at 1 -> rise 4 cycles after rst deasserts.
REQ-035 DEBOUNCE_CYCLES=1 build, random in -> level equals in delayed one cycle, rise/fall match edges exactly.

Source files
------------

// File: rtl/sync_pkg.sv
// sync_pkg: shared types for the sync_debounce block.
// Holds the lane FSM encoding and parameter limits.
package sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } debounce_state_e;

  localparam int DEB_MIN = 1;
  localparam int DEB_MAX = 65535;

  // Stability counter must hold 0..cycles.
  function automatic int stab_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_lane.sv
// sync_debounce_lane: one debounced lane (FSM, stability
// counter, registered level, edge pulses, event counter).
// Ports: clk, rst (sync, active-high), i_in (synced sample),
//   i_clr (clear event counter), o_level, o_rise, o_fall,
//   o_cnt (saturating count of committed transitions).
module sync_debounce_lane
  import sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in,
  input  logic                 i_clr,
  output logic                 o_level,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  localparam int SW = stab_cnt_w(DEBOUNCE_CYCLES);
  // Count value held just before the commit edge.
  // Stable states keep the counter at 0, so with a
  // single-cycle debounce the first differing sample
  // commits straight away.
  localparam logic [SW-1:0] LAST =
    SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  debounce_state_e      r_state;
  debounce_state_e      w_state_nxt;
  logic [SW-1:0]        r_stab;
  logic [SW-1:0]        w_stab_nxt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_commit_hi;
  logic                 w_commit_lo;
  logic                 w_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STABLE_LO;
      r_stab  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stab  <= w_stab_nxt;
      r_level <= (r_level | w_commit_hi) & ~w_commit_lo;
      r_rise  <= w_commit_hi;
      r_fall  <= w_commit_lo;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    w_commit_hi = 1'b0;
    w_commit_lo = 1'b0;
    unique case (r_state)
      STABLE_LO, PEND_HI: begin
        if (!i_in) begin
          w_state_nxt = STABLE_LO;
          w_stab_nxt  = '0;
        end else if (r_stab == LAST) begin
          w_state_nxt = STABLE_HI;
          w_stab_nxt  = '0;
          w_commit_hi = 1'b1;
        end else begin
          w_state_nxt = PEND_HI;
          w_stab_nxt  = r_stab + 1'b1;
        end
      end
      STABLE_HI, PEND_LO: begin
        if (i_in) begin
          w_state_nxt = STABLE_HI;
          w_stab_nxt  = '0;
        end else if (r_stab == LAST) begin
          w_state_nxt = STABLE_LO;
          w_stab_nxt  = '0;
          w_commit_lo = 1'b1;
        end else begin
          w_state_nxt = PEND_LO;
          w_stab_nxt  = r_stab + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_stab_nxt  = '0;
      end
    endcase
  end

  // A clear that coincides with a commit still
  // records that commit.
  always_comb begin
    w_commit  = w_commit_hi | w_commit_lo;
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = w_commit ? CNT_ONE : '0;
    end else if (w_commit && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: DATA_WIDTH independent debounced lanes.
// Ports: clk, rst (sync, active-high), in, clr_cnt,
//   level, rise, fall, event_cnt (lane i at i*CNT_WIDTH).
module sync_debounce
  import sync_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           in,
  input  logic                            clr_cnt,
  output logic [DATA_WIDTH-1:0]           level,
  output logic [DATA_WIDTH-1:0]           rise,
  output logic [DATA_WIDTH-1:0]           fall,
  output logic [DATA_WIDTH*CNT_WIDTH-1:0] event_cnt
);

  if ((DEBOUNCE_CYCLES < DEB_MIN) ||
      (DEBOUNCE_CYCLES > DEB_MAX)) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be 1..65535");
  end

  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH must be at least 1");
  end

  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("DATA_WIDTH must be at least 1");
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    sync_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_in   (in[i]),
      .i_clr  (clr_cnt),
      .o_level(level[i]),
      .o_rise (rise[i]),
      .o_fall (fall[i]),
      .o_cnt  (event_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule
